// File: rtl/emoji_clip_recorder.sv
// emoji_clip_recorder: records codec samples into a 2**ADDR_W-word clip memory.
// Optional feature macro: VOX_TRIGGER_EN (start arms the recorder, and the first sample with
// |audio_in| >= VOX_THRESH opens the clip and is stored at address 0).
// Ports:
//   FPGA_clock, reset           system clock, asynchronous active-high reset
//   ascii_code                  command code; REC_CODE starts, STOP_CODE stops (acted on when it changes)
//   audio_in, audio_in_valid    signed sample and its one-clock strobe
//   mem_addr, mem_data, mem_wren  registered clip memory write port
//   recording, done             RECORD / DONE state flags
//   clip_len                    number of samples stored in the last clip
module emoji_clip_recorder #(
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] REC_CODE  = 8'h84,
    parameter logic [7:0] STOP_CODE = 8'h85
`ifdef VOX_TRIGGER_EN
    ,
    parameter logic [15:0] VOX_THRESH = 16'd2048
`endif
) (
    input  logic              FPGA_clock,
    input  logic              reset,
    input  logic [7:0]        ascii_code,
    input  logic [15:0]       audio_in,
    input  logic              audio_in_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W:0]   clip_len
);
    typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;
    state_t            r_state, w_next;
    logic [7:0]        r_prev_ascii;
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   w_wptr_inc;
    logic              w_start, w_stop, w_write, w_arm_hit;
    assign w_start    = (ascii_code != r_prev_ascii) && (ascii_code == REC_CODE);
    assign w_stop     = (ascii_code != r_prev_ascii) && (ascii_code == STOP_CODE);
    assign w_wptr_inc = r_wptr + 1'b1;
`ifdef VOX_TRIGGER_EN
    localparam state_t START_ST = ARMED;
    logic [16:0] w_mag;
    // 17 bits so that -32768 becomes +32768 instead of overflowing
    assign w_mag     = audio_in[15] ? {1'b0, ~audio_in} + 17'd1 : {1'b0, audio_in};
    assign w_arm_hit = (r_state == ARMED) && audio_in_valid && (w_mag >= {1'b0, VOX_THRESH});
`else
    localparam state_t START_ST = RECORD;
    assign w_arm_hit = 1'b0;
`endif
    // The pointer's top bit marks a full clip; start and stop both suppress a coincident sample
    assign w_write = !w_start && !w_stop &&
                     (w_arm_hit || ((r_state == RECORD) && audio_in_valid && !r_wptr[ADDR_W]));

    always_ff @(posedge FPGA_clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // A full clip leaves RECORD one clock after its last write, so that write's pulse stays inside RECORD
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_start ? START_ST : r_state;
            ARMED:      w_next = w_start ? ARMED : w_stop ? DONE : w_arm_hit ? RECORD : ARMED;
            RECORD:     w_next = w_start ? START_ST : (w_stop || r_wptr[ADDR_W]) ? DONE : RECORD;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        recording = r_state == RECORD;
        done      = r_state == DONE;
    end

    always_ff @(posedge FPGA_clock or posedge reset) begin
        if (reset) begin
            r_prev_ascii <= '0;
            r_wptr       <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_wren     <= 1'b0;
            clip_len     <= '0;
        end else begin
            r_prev_ascii <= ascii_code;
            mem_wren     <= w_write;
            if (w_write) begin
                mem_addr <= r_wptr[ADDR_W-1:0];
                mem_data <= audio_in;
                r_wptr   <= w_wptr_inc;
                clip_len <= w_wptr_inc;
            end
            if (w_start)
                r_wptr <= '0;
            // A fresh start from IDLE/DONE keeps the old length visible until the first new write
            if ((w_start && (r_state == RECORD || r_state == ARMED)) || (w_stop && r_state == ARMED))
                clip_len <= '0;
        end
    end
endmodule

// File: tb/tb_emoji_clip_recorder.sv
// tb_emoji_clip_recorder: scoreboard bench for emoji_clip_recorder
module tb_emoji_clip_recorder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ascii_code = 8'h00;
    logic [15:0] audio_in = 16'h0000;
    logic        audio_in_valid = 1'b0;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren, recording, done;
    logic [12:0] clip_len;
    int n_cmp = 0, n_err = 0, cyc = 0, exp_ptr = 0;
    typedef struct {logic [11:0] a; logic [15:0] d; int c;} wr_t;
    wr_t sb[$];

    emoji_clip_recorder dut (
        .FPGA_clock(clk), .reset(rst), .ascii_code(ascii_code), .audio_in(audio_in),
        .audio_in_valid(audio_in_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .recording(recording), .done(done), .clip_len(clip_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write pulse must match the oldest outstanding expected write, one clock after its valid
    always @(negedge clk) begin
        wr_t e;
        if (!rst && mem_wren) begin
            if (sb.size() == 0)
                chk("unexpected_wren", 32'(mem_wren), 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(mem_data), 32'(e.d));
                chk("wr_cycle", cyc, e.c);
                chk("wr_in_record", 32'(recording), 1);
            end
        end
    end

    task automatic code(input logic [7:0] c);
        @(negedge clk);
        ascii_code = c;
        @(negedge clk);
    endtask

    task automatic smp(input logic [15:0] d, input bit wr);
        @(negedge clk);
        audio_in = d;
        audio_in_valid = 1'b1;
        if (wr) begin
            sb.push_back('{a: exp_ptr[11:0], d: d, c: cyc + 1});
            exp_ptr++;
        end
        @(negedge clk);
        audio_in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", 32'(mem_data), 0);
        chk("rst_wren", 32'(mem_wren), 0);
        chk("rst_rec", 32'(recording), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_len", 32'(clip_len), 0);
        rst = 1'b0;
`ifdef VOX_TRIGGER_EN
        code(8'h84);
        chk("vox_armed_rec", 32'(recording), 0);
        smp(16'd100, 1'b0);
        smp(16'hF801, 1'b0);
        chk("vox_below_rec", 32'(recording), 0);
        smp(16'hF800, 1'b1);
        chk("vox_len", 32'(clip_len), 1);
        chk("vox_rec", 32'(recording), 1);
        code(8'h41);
        code(8'h84);
        exp_ptr = 0;
        chk("vox_rearm_len", 32'(clip_len), 0);
        code(8'h85);
        chk("vox_stop_done", 32'(done), 1);
        chk("vox_stop_len", 32'(clip_len), 0);
`else
        code(8'h84);
        chk("start_rec", 32'(recording), 1);
        chk("start_done", 32'(done), 0);
        smp(16'h0001, 1'b1);
        chk("len_1", 32'(clip_len), 1);
        smp(16'h8000, 1'b1);
        smp(16'h7FFF, 1'b1);
        chk("len_3", 32'(clip_len), 3);
        chk("rec_3", 32'(recording), 1);
        smp(16'h0004, 1'b1);
        smp(16'h0005, 1'b1);
        code(8'h41);
        chk("other_code_rec", 32'(recording), 1);
        code(8'h84);
        exp_ptr = 0;
        chk("restart_len", 32'(clip_len), 0);
        chk("restart_rec", 32'(recording), 1);
        smp(16'h1234, 1'b1);
        chk("restart_len1", 32'(clip_len), 1);
        for (int i = 0; i < 9; i++) smp(16'(i * 3 + 100), 1'b1);
        chk("len_10", 32'(clip_len), 10);
        @(negedge clk);
        ascii_code = 8'h85;
        audio_in = 16'hDEAD;
        audio_in_valid = 1'b1;
        @(negedge clk);
        audio_in_valid = 1'b0;
        chk("stop_done", 32'(done), 1);
        chk("stop_rec", 32'(recording), 0);
        chk("stop_len", 32'(clip_len), 10);
        chk("stop_wren", 32'(mem_wren), 0);
        code(8'h41);
        code(8'h85);
        chk("stop_idle_done", 32'(done), 1);
        chk("stop_idle_len", 32'(clip_len), 10);
        code(8'h84);
        exp_ptr = 0;
        chk("full_start_rec", 32'(recording), 1);
        chk("full_start_done", 32'(done), 0);
        chk("len_held", 32'(clip_len), 10);
        for (int i = 0; i < 4096; i++) smp(16'(i * 7 + 3), 1'b1);
        chk("full_last_rec", 32'(recording), 1);
        @(negedge clk);
        chk("full_done", 32'(done), 1);
        chk("full_rec", 32'(recording), 0);
        chk("full_len", 32'(clip_len), 4096);
        chk("full_wren", 32'(mem_wren), 0);
        smp(16'h5555, 1'b0);
        chk("over_len", 32'(clip_len), 4096);
        code(8'h41);
        code(8'h84);
        exp_ptr = 0;
        smp(16'h0011, 1'b1);
        smp(16'h0022, 1'b1);
        @(negedge clk);
        audio_in = 16'h7777;
        audio_in_valid = 1'b1;
        @(posedge clk);
        #2;
        audio_in_valid = 1'b0;
        chk("pre_rst_wren", 32'(mem_wren), 1);
        rst = 1'b1;
        #1;
        chk("arst_wren", 32'(mem_wren), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_data", 32'(mem_data), 0);
        chk("arst_rec", 32'(recording), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_len", 32'(clip_len), 0);
        ascii_code = 8'h41;
        @(negedge clk);
        rst = 1'b0;
        smp(16'h0009, 1'b0);
        chk("post_rst_idle", 32'(recording), 0);
        code(8'h84);
        exp_ptr = 0;
        chk("post_rst_rec", 32'(recording), 1);
        smp(16'hABCD, 1'b1);
        chk("post_rst_len", 32'(clip_len), 1);
`endif
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
